ic_mem_resp: RTL and testbench



---
 rtl/ic_mem_resp_pkg.sv | 11 +
 rtl/ic_mem_resp_if.sv | 24 ++
 rtl/ic_mem_resp_sync_fifo.sv | 42 ++++
 rtl/ic_mem_resp.sv | 62 ++++++
 tb/tb_ic_mem_resp.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ic_mem_resp_pkg.sv
// ic_mem_resp_pkg: shared line-fill types (address, xid, line data, request struct) and the xid count
package ic_mem_resp_pkg;
  typedef logic [26:4] ic_mem_addr_t;
  typedef logic [1:0] ic_xid_t;
  typedef logic [127:0] ic_line_data_t;
  typedef struct packed {
    ic_mem_addr_t addr;
    ic_xid_t xid;
  } ic_mem_req_t;
  localparam int IC_XID_COUNT = 4;
endpackage

// File: rtl/ic_mem_resp_if.sv
// ic_mem_resp_if: icache request/response and back-end read signals; master = icache+back-end model, slave = responder
interface ic_mem_resp_if;
  import ic_mem_resp_pkg::*;
  ic_mem_addr_t ic_mem_addr;
  ic_xid_t ic_mem_xid;
  logic ic_mem_re;
  logic mem_ic_ready;
  logic mem_ic_valid;
  ic_xid_t mem_ic_xid;
  ic_line_data_t mem_ic_data;
  logic be_req;
  ic_mem_addr_t be_addr;
  logic be_gnt;
  logic be_rvalid;
  ic_line_data_t be_rdata;
  modport master (
    output ic_mem_addr, ic_mem_xid, ic_mem_re, be_gnt, be_rvalid, be_rdata,
    input mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, be_req, be_addr
  );
  modport slave (
    input ic_mem_addr, ic_mem_xid, ic_mem_re, be_gnt, be_rvalid, be_rdata,
    output mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, be_req, be_addr
  );
endinterface

// File: rtl/ic_mem_resp_sync_fifo.sv
// ic_sync_fifo: WIDTH x DEPTH synchronous FIFO (clk, rst_p, push/wdata, pop/rdata, full, empty); pop+push while full is legal
module ic_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst_p) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ic_mem_resp.sv
// ic_mem_resp: in-order icache line-fill responder (clk, rst_p, bus slave: icache req/resp + back-end read port, xid_err sticky); IC_MEM_RESP_XID_CHECK_EN adds duplicate-xid detection
module ic_mem_resp
  import ic_mem_resp_pkg::*;
#(
  parameter int REQ_DEPTH = 2,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         rst_p,
  ic_mem_resp_if.slave bus,
  output logic         xid_err
);
  ic_mem_req_t req_in, req_head;
  ic_xid_t tag_head;
  logic [2:0] outstanding;
  logic accept, issue, tag_pop, req_full, req_empty, tag_full, tag_empty, dup;
  assign req_in = '{addr: bus.ic_mem_addr, xid: bus.ic_mem_xid};
  assign bus.mem_ic_ready = !req_full && (outstanding < 3'(MAX_OUT));
  assign accept = bus.ic_mem_re && bus.mem_ic_ready;
  assign bus.be_req = !req_empty && !tag_full;
  assign bus.be_addr = req_head.addr;
  assign issue = bus.be_req && bus.be_gnt;
  assign tag_pop = bus.be_rvalid && !tag_empty;
  ic_sync_fifo #(.WIDTH($bits(ic_mem_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(clk), .rst_p(rst_p), .push(accept), .wdata(req_in), .pop(issue),
    .rdata(req_head), .full(req_full), .empty(req_empty)
  );
  ic_sync_fifo #(.WIDTH($bits(ic_xid_t)), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk(clk), .rst_p(rst_p), .push(issue), .wdata(req_head.xid), .pop(tag_pop),
    .rdata(tag_head), .full(tag_full), .empty(tag_empty)
  );
`ifdef IC_MEM_RESP_XID_CHECK_EN
  logic [IC_XID_COUNT-1:0] inflight, set_v, clr_v;
  always_comb begin
    set_v = accept ? IC_XID_COUNT'(1) << bus.ic_mem_xid : '0;
    clr_v = bus.mem_ic_valid ? IC_XID_COUNT'(1) << bus.mem_ic_xid : '0;
    dup = accept && inflight[bus.ic_mem_xid] && !clr_v[bus.ic_mem_xid];
  end
  always_ff @(posedge clk)
    if (rst_p) inflight <= '0;
    else inflight <= (inflight & ~clr_v) | set_v;
`else
  assign dup = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst_p) begin
      bus.mem_ic_valid <= 1'b0;
      bus.mem_ic_xid <= '0;
      bus.mem_ic_data <= '0;
      xid_err <= 1'b0;
      outstanding <= '0;
    end else begin
      bus.mem_ic_valid <= tag_pop;
      if (tag_pop) begin
        bus.mem_ic_xid <= tag_head;
        bus.mem_ic_data <= bus.be_rdata;
      end
      if ((bus.be_rvalid && tag_empty) || dup) xid_err <= 1'b1;
      outstanding <= outstanding + 3'(accept) - 3'(bus.mem_ic_valid);
    end
  end
endmodule

// File: tb/tb_ic_mem_resp.sv
// tb_ic_mem_resp: directed self-checking bench for ic_mem_resp
module tb_ic_mem_resp;
  logic clk = 1'b0;
  logic rst_p = 1'b1;
  logic xid_err;
  int checks = 0;
  int failures = 0;
`ifdef IC_MEM_RESP_XID_CHECK_EN
  localparam logic DUP_ERR = 1'b1;
`else
  localparam logic DUP_ERR = 1'b0;
`endif
  localparam logic [127:0] A5 = {16{8'hA5}};
  ic_mem_resp_if bus();
  ic_mem_resp #(.REQ_DEPTH(2), .MAX_OUT(4)) dut (
    .clk(clk), .rst_p(rst_p), .bus(bus), .xid_err(xid_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.ic_mem_re = 1'b0;
    bus.be_gnt = 1'b0;
    bus.be_rvalid = 1'b0;
    rst_p = 1'b1;
    step();
    rst_p = 1'b0;
  endtask
  task automatic send(input logic [22:0] a, input logic [1:0] x);
    int n = 0;
    bus.ic_mem_addr = a;
    bus.ic_mem_xid = x;
    bus.ic_mem_re = 1'b1;
    while (!bus.mem_ic_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", bus.mem_ic_ready, 1);
    step();
    bus.ic_mem_re = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.be_req && n < 20) begin
      step();
      n++;
    end
    check("drain_wait", bus.be_req, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    bus.ic_mem_addr = '0;
    bus.ic_mem_xid = '0;
    bus.be_rdata = '0;
    do_reset();
    check("rst_valid", bus.mem_ic_valid, 0);
    check("rst_xid", bus.mem_ic_xid, 0);
    check("rst_data", bus.mem_ic_data, 0);
    check("rst_be_req", bus.be_req, 0);
    check("rst_err", xid_err, 0);
    check("rst_ready", bus.mem_ic_ready, 1);
    bus.ic_mem_addr = 23'h000010;
    bus.ic_mem_xid = 2'd2;
    bus.ic_mem_re = 1'b1;
    bus.be_gnt = 1'b1;
    step();
    bus.ic_mem_re = 1'b0;
    check("s_be_req", bus.be_req, 1);
    check("s_be_addr", bus.be_addr, 23'h000010);
    step();
    check("s_popped", bus.be_req, 0);
    step();
    step();
    bus.be_rvalid = 1'b1;
    bus.be_rdata = A5;
    check("s_no_early", bus.mem_ic_valid, 0);
    step();
    bus.be_rvalid = 1'b0;
    check("s_valid", bus.mem_ic_valid, 1);
    check("s_xid", bus.mem_ic_xid, 2);
    check("s_data", bus.mem_ic_data, A5);
    step();
    check("s_pulse", bus.mem_ic_valid, 0);
    check("s_hold", bus.mem_ic_data, A5);
    do_reset();
    send(23'd1, 2'd0);
    send(23'd2, 2'd1);
    check("full_ready", bus.mem_ic_ready, 0);
    check("full_be_addr", bus.be_addr, 23'd1);
    bus.be_gnt = 1'b1;
    send(23'd3, 2'd2);
    send(23'd4, 2'd3);
    check("max_ready", bus.mem_ic_ready, 0);
    wait_idle();
    check("max_ready_empty", bus.mem_ic_ready, 0);
    for (int i = 0; i < 4; i++) begin
      bus.be_rvalid = 1'b1;
      bus.be_rdata = 128'(i + 100);
      step();
      check("ord_valid", bus.mem_ic_valid, 1);
      check("ord_xid", bus.mem_ic_xid, 128'(i));
      check("ord_data", bus.mem_ic_data, 128'(i + 100));
      if (i == 0) check("max_still_busy", bus.mem_ic_ready, 0);
      if (i == 1) check("max_freed", bus.mem_ic_ready, 1);
    end
    bus.be_rvalid = 1'b0;
    step();
    check("ord_end", bus.mem_ic_valid, 0);
    do_reset();
    bus.be_gnt = 1'b1;
    send(23'd5, 2'd0);
    send(23'd6, 2'd1);
    send(23'd7, 2'd2);
    wait_idle();
    check("c3_ready", bus.mem_ic_ready, 1);
    bus.be_rvalid = 1'b1;
    bus.be_rdata = 128'h7;
    step();
    bus.be_rvalid = 1'b0;
    check("c3_valid", bus.mem_ic_valid, 1);
    check("c3_xid", bus.mem_ic_xid, 0);
    bus.ic_mem_addr = 23'd8;
    bus.ic_mem_xid = 2'd3;
    bus.ic_mem_re = 1'b1;
    step();
    bus.ic_mem_re = 1'b0;
    check("c3_same_ready", bus.mem_ic_ready, 1);
    check("c3_new_req", bus.be_req, 1);
    step();
    check("c3_ready_after", bus.mem_ic_ready, 1);
    do_reset();
    bus.be_gnt = 1'b1;
    send(23'd9, 2'd0);
    send(23'd10, 2'd1);
    wait_idle();
    rst_p = 1'b1;
    step();
    rst_p = 1'b0;
    check("mr_err0", xid_err, 0);
    bus.be_rvalid = 1'b1;
    step();
    bus.be_rvalid = 1'b0;
    check("mr_no_valid", bus.mem_ic_valid, 0);
    check("mr_err", xid_err, 1);
    check("mr_ready", bus.mem_ic_ready, 1);
    step();
    check("mr_sticky", xid_err, 1);
    do_reset();
    bus.be_gnt = 1'b1;
    send(23'd11, 2'd1);
    send(23'd12, 2'd1);
    wait_idle();
    step();
    check("dup_err", xid_err, DUP_ERR);
    for (int i = 0; i < 2; i++) begin
      bus.be_rvalid = 1'b1;
      bus.be_rdata = 128'(i + 200);
      step();
      check("dup_valid", bus.mem_ic_valid, 1);
      check("dup_xid", bus.mem_ic_xid, 1);
      check("dup_data", bus.mem_ic_data, 128'(i + 200));
    end
    bus.be_rvalid = 1'b0;
    step();
    check("dup_err_end", xid_err, DUP_ERR);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
